// File: rtl/ascon_ctrl_fsm.sv
// Control FSM for the ASCON-128 datapath: round sequencing, round counter and XOR enables.
// Optional abort input enabled by defining ASCON_CTRL_ABORT_EN.
module ascon_ctrl_fsm #(
  parameter int ROUNDS_A  = 12,
  parameter int ROUNDS_B  = 6,
  parameter int AD_BLOCKS = 1,
  parameter int PT_BLOCKS = 3
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic       data_valid_i,
`ifdef ASCON_CTRL_ABORT_EN
  input  logic       abort_i,
`endif
  output logic [3:0] round_o,
  output logic       init_state_o,
  output logic       en_reg_state_o,
  output logic       en_xor_data_begin_o,
  output logic       en_xor_key_begin_o,
  output logic       en_xor_key_end_o,
  output logic       en_xor_lsb_o,
  output logic       cipher_valid_o,
  output logic       tag_valid_o,
  output logic       done_o
);

  localparam int MAX_BLK = (AD_BLOCKS > PT_BLOCKS) ? AD_BLOCKS : PT_BLOCKS;
  localparam int BLK_W   = $clog2(MAX_BLK) + 1;

  localparam logic [3:0]       RND_LAST = 4'(ROUNDS_A - 1);
  localparam logic [3:0]       RND_B0   = 4'(ROUNDS_A - ROUNDS_B);
  localparam logic [BLK_W-1:0] AD_LAST  = BLK_W'(AD_BLOCKS - 1);
  localparam logic [BLK_W-1:0] PT_LAST  = BLK_W'(PT_BLOCKS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_WAIT_AD, S_AD, S_WAIT_PT, S_PT, S_FINAL, S_END
  } state_t;

  state_t           state, state_next;
  logic [3:0]       rnd, rnd_next;
  logic [BLK_W-1:0] ad_blk, ad_blk_next;
  logic [BLK_W-1:0] pt_blk, pt_blk_next;
  logic             last_rnd;

  assign last_rnd = (rnd == RND_LAST);

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state  <= S_IDLE;
      rnd    <= '0;
      ad_blk <= '0;
      pt_blk <= '0;
    end else begin
      state  <= state_next;
      rnd    <= rnd_next;
      ad_blk <= ad_blk_next;
      pt_blk <= pt_blk_next;
    end
  end

  // Round counter is reloaded on every entry to a round state, so it never wraps.
  always_comb begin
    state_next  = state;
    rnd_next    = rnd;
    ad_blk_next = ad_blk;
    pt_blk_next = pt_blk;
    case (state)
      S_IDLE: begin
        rnd_next    = '0;
        ad_blk_next = '0;
        pt_blk_next = '0;
        if (start_i) state_next = S_INIT;
      end
      S_INIT: begin
        rnd_next = rnd + 4'd1;
        if (last_rnd) begin
          state_next = S_WAIT_AD;
          rnd_next   = '0;
        end
      end
      S_WAIT_AD: begin
        if (data_valid_i) begin
          state_next = S_AD;
          rnd_next   = RND_B0;
        end
      end
      S_AD: begin
        rnd_next = rnd + 4'd1;
        if (last_rnd) begin
          rnd_next    = '0;
          ad_blk_next = ad_blk + 1'b1;
          state_next  = (ad_blk == AD_LAST) ? S_WAIT_PT : S_WAIT_AD;
        end
      end
      S_WAIT_PT: begin
        if (data_valid_i) begin
          if (pt_blk < PT_LAST) begin
            state_next  = S_PT;
            rnd_next    = RND_B0;
            pt_blk_next = pt_blk + 1'b1;
          end else begin
            state_next = S_FINAL;
            rnd_next   = '0;
          end
        end
      end
      S_PT: begin
        rnd_next = rnd + 4'd1;
        if (last_rnd) begin
          state_next = S_WAIT_PT;
          rnd_next   = '0;
        end
      end
      S_FINAL: begin
        rnd_next = rnd + 4'd1;
        if (last_rnd) begin
          state_next = S_END;
          rnd_next   = '0;
        end
      end
      S_END: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
        rnd_next   = '0;
      end
    endcase
`ifdef ASCON_CTRL_ABORT_EN
    if (abort_i && (state != S_IDLE)) begin
      state_next = S_IDLE;
      rnd_next   = '0;
    end
`endif
  end

  // Moore decode: outputs depend only on registered state, round and block counters.
  always_comb begin
    round_o             = '0;
    init_state_o        = 1'b0;
    en_reg_state_o      = 1'b0;
    en_xor_data_begin_o = 1'b0;
    en_xor_key_begin_o  = 1'b0;
    en_xor_key_end_o    = 1'b0;
    en_xor_lsb_o        = 1'b0;
    cipher_valid_o      = 1'b0;
    tag_valid_o         = 1'b0;
    done_o              = 1'b0;
    case (state)
      S_INIT: begin
        round_o          = rnd;
        en_reg_state_o   = 1'b1;
        init_state_o     = (rnd == 4'd0);
        en_xor_key_end_o = last_rnd;
      end
      S_AD: begin
        round_o             = rnd;
        en_reg_state_o      = 1'b1;
        en_xor_data_begin_o = (rnd == RND_B0);
        en_xor_lsb_o        = last_rnd && (ad_blk == AD_LAST);
      end
      S_PT: begin
        round_o             = rnd;
        en_reg_state_o      = 1'b1;
        en_xor_data_begin_o = (rnd == RND_B0);
        cipher_valid_o      = (rnd == RND_B0);
      end
      S_FINAL: begin
        round_o             = rnd;
        en_reg_state_o      = 1'b1;
        en_xor_data_begin_o = (rnd == 4'd0);
        en_xor_key_begin_o  = (rnd == 4'd0);
        cipher_valid_o      = (rnd == 4'd0);
        en_xor_key_end_o    = last_rnd;
      end
      S_END: begin
        tag_valid_o = 1'b1;
        done_o      = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ascon_ctrl_fsm.sv
// Directed bench for ascon_ctrl_fsm: expected outputs per cycle come from the documented run timeline.
module tb_ascon_ctrl_fsm;

  logic       clock_i = 1'b0;
  logic       reset_i, start_i, data_valid_i;
`ifdef ASCON_CTRL_ABORT_EN
  logic       abort_i;
`endif
  logic [3:0] round_o;
  logic       init_state_o, en_reg_state_o, en_xor_data_begin_o, en_xor_key_begin_o;
  logic       en_xor_key_end_o, en_xor_lsb_o, cipher_valid_o, tag_valid_o, done_o;

  int vectors = 0;
  int errors  = 0;

  always #5 clock_i = ~clock_i;

  ascon_ctrl_fsm dut (
    .clock_i             (clock_i),
    .reset_i             (reset_i),
    .start_i             (start_i),
    .data_valid_i        (data_valid_i),
`ifdef ASCON_CTRL_ABORT_EN
    .abort_i             (abort_i),
`endif
    .round_o             (round_o),
    .init_state_o        (init_state_o),
    .en_reg_state_o      (en_reg_state_o),
    .en_xor_data_begin_o (en_xor_data_begin_o),
    .en_xor_key_begin_o  (en_xor_key_begin_o),
    .en_xor_key_end_o    (en_xor_key_end_o),
    .en_xor_lsb_o        (en_xor_lsb_o),
    .cipher_valid_o      (cipher_valid_o),
    .tag_valid_o         (tag_valid_o),
    .done_o              (done_o)
  );

  // {round[3:0], init, en_reg, data_begin, key_begin, key_end, lsb, cipher_valid, tag_valid, done}
  logic [12:0] obs;
  assign obs = {round_o, init_state_o, en_reg_state_o, en_xor_data_begin_o, en_xor_key_begin_o,
                en_xor_key_end_o, en_xor_lsb_o, cipher_valid_o, tag_valid_o, done_o};

  // Expected output vector at cycle tt of an unstalled default run (start sampled at cycle 0).
  function automatic logic [12:0] exp_vec(input int tt);
    logic [12:0] v;
    int b;
    v = '0;
    b = (tt <= 26) ? 21 : 28;
    if (tt >= 1 && tt <= 12) begin
      v[12:9] = 4'(tt - 1); v[7] = 1'b1;
      if (tt == 1)  v[8] = 1'b1;
      if (tt == 12) v[4] = 1'b1;
    end else if (tt >= 14 && tt <= 19) begin
      v[12:9] = 4'(tt - 8); v[7] = 1'b1;
      if (tt == 14) v[6] = 1'b1;
      if (tt == 19) v[3] = 1'b1;
    end else if ((tt >= 21 && tt <= 26) || (tt >= 28 && tt <= 33)) begin
      v[12:9] = 4'(tt - b + 6); v[7] = 1'b1;
      if (tt == b) begin v[6] = 1'b1; v[2] = 1'b1; end
    end else if (tt >= 35 && tt <= 46) begin
      v[12:9] = 4'(tt - 35); v[7] = 1'b1;
      if (tt == 35) begin v[6] = 1'b1; v[5] = 1'b1; v[2] = 1'b1; end
      if (tt == 46) v[4] = 1'b1;
    end else if (tt == 47) begin
      v[1] = 1'b1; v[0] = 1'b1;
    end
    return v;
  endfunction

  // Apply inputs, cross one rising edge, return at the following falling edge.
  task automatic step(input logic st, input logic dv, input logic rs);
    start_i      = st;
    data_valid_i = dv;
    reset_i      = rs;
    @(posedge clock_i);
    @(negedge clock_i);
  endtask

  task automatic test_reset;
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1, 1'b1);
      vectors++;
      if (obs !== 13'h0) begin
        errors++;
        $display("FAIL reset_hold[%0d]: got %h expected %h", i, obs, 13'h0);
      end
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0);
      vectors++;
      if (obs !== 13'h0) begin
        errors++;
        $display("FAIL reset_idle[%0d]: got %h expected %h", i, obs, 13'h0);
      end
    end
  endtask

  task automatic test_nominal;
    int en_cnt, done_cnt;
    en_cnt = 0; done_cnt = 0;
    step(1'b1, 1'b1, 1'b0);
    for (int t = 1; t <= 50; t++) begin
      vectors++;
      if (obs !== exp_vec(t)) begin
        errors++;
        $display("FAIL nominal@%0d: got %h expected %h", t, obs, exp_vec(t));
      end
      if (en_reg_state_o === 1'b1) en_cnt++;
      if (done_o === 1'b1) done_cnt++;
      step(1'b0, 1'b1, 1'b0);
    end
    vectors++;
    if (en_cnt != 42) begin
      errors++;
      $display("FAIL nominal_round_cycles: got %0d expected %0d", en_cnt, 42);
    end
    vectors++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL nominal_done_pulses: got %0d expected %0d", done_cnt, 1);
    end
  endtask

  task automatic test_start_held;
    logic [12:0] e;
    step(1'b1, 1'b1, 1'b0);
    for (int t = 1; t <= 49; t++) begin
      e = (t <= 48) ? exp_vec(t) : exp_vec(t - 48);
      vectors++;
      if (obs !== e) begin
        errors++;
        $display("FAIL start_held@%0d: got %h expected %h", t, obs, e);
      end
      step(1'b1, 1'b1, 1'b0);
    end
    step(1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_stall;
    int tt, done_t;
    done_t = -1;
    step(1'b1, 1'b1, 1'b0);
    for (int t = 1; t <= 55; t++) begin
      tt = (t < 20) ? t : ((t <= 25) ? 20 : t - 5);
      vectors++;
      if (obs !== exp_vec(tt)) begin
        errors++;
        $display("FAIL stall@%0d: got %h expected %h", t, obs, exp_vec(tt));
      end
      if (done_o === 1'b1 && done_t < 0) done_t = t;
      step(1'b0, !(t >= 20 && t <= 24), 1'b0);
    end
    vectors++;
    if (done_t != 52) begin
      errors++;
      $display("FAIL stall_done_cycle: got %0d expected %0d", done_t, 52);
    end
  endtask

  task automatic test_reset_mid;
    logic [12:0] e;
    int done_t;
    done_t = -1;
    step(1'b1, 1'b1, 1'b0);
    for (int t = 1; t <= 35; t++) begin
      e = (t <= 30) ? exp_vec(t) : 13'h0;
      vectors++;
      if (obs !== e) begin
        errors++;
        $display("FAIL reset_mid@%0d: got %h expected %h", t, obs, e);
      end
      step(1'b0, 1'b1, t == 30);
    end
    step(1'b1, 1'b1, 1'b0);
    for (int t = 1; t <= 48; t++) begin
      vectors++;
      if (obs !== exp_vec(t)) begin
        errors++;
        $display("FAIL rerun@%0d: got %h expected %h", t, obs, exp_vec(t));
      end
      if (done_o === 1'b1 && done_t < 0) done_t = t;
      step(1'b0, 1'b1, 1'b0);
    end
    vectors++;
    if (done_t != 47) begin
      errors++;
      $display("FAIL rerun_done_cycle: got %0d expected %0d", done_t, 47);
    end
  endtask

`ifdef ASCON_CTRL_ABORT_EN
  task automatic test_abort;
    logic [12:0] e;
    int done_cnt;
    done_cnt = 0;
    step(1'b1, 1'b1, 1'b0);
    for (int t = 1; t <= 50; t++) begin
      e = (t <= 40) ? exp_vec(t) : 13'h0;
      vectors++;
      if (obs !== e) begin
        errors++;
        $display("FAIL abort@%0d: got %h expected %h", t, obs, e);
      end
      if (done_o === 1'b1 || tag_valid_o === 1'b1) done_cnt++;
      abort_i = (t == 40);
      step(1'b0, 1'b1, 1'b0);
    end
    abort_i = 1'b0;
    vectors++;
    if (done_cnt != 0) begin
      errors++;
      $display("FAIL abort_done_pulses: got %0d expected %0d", done_cnt, 0);
    end
    step(1'b1, 1'b1, 1'b0);
    for (int t = 1; t <= 14; t++) begin
      vectors++;
      if (obs !== exp_vec(t)) begin
        errors++;
        $display("FAIL abort_restart@%0d: got %h expected %h", t, obs, exp_vec(t));
      end
      step(1'b0, 1'b1, 1'b0);
    end
    step(1'b0, 1'b0, 1'b1);
  endtask
`endif

  initial begin
    reset_i      = 1'b1;
    start_i      = 1'b0;
    data_valid_i = 1'b0;
`ifdef ASCON_CTRL_ABORT_EN
    abort_i      = 1'b0;
`endif
    @(negedge clock_i);
    test_reset();
    test_nominal();
    test_start_held();
    test_stall();
    test_reset_mid();
`ifdef ASCON_CTRL_ABORT_EN
    test_abort();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded %0d time units", 200000);
    $fatal(1);
  end

endmodule
